seg_link_rx: RTL

//  Receiving end of the segment serial link (seg_data_left / seg_data_right / seg_data_cs).

---
 rtl/seg_link_pkg.sv | 21 ++
 rtl/seg_link_rx_if.sv | 28 ++
 rtl/seg_sync2.sv | 25 ++
 rtl/seg_link_rx.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/seg_link_pkg.sv
// Shared definitions for the segment serial link (receiver and transmitter).
package seg_link_pkg;

    localparam int unsigned SEG_FRAME_BITS = 8;
    localparam int unsigned SEG_BIT_CYCLES = 4;
    localparam int unsigned SEG_CNT_W      = 8;

    typedef enum logic [2:0] {
        IDLE,
        SAMP,
        DONE,
        ABORT,
        WAIT_CS
    } seg_state_e;

    // A frame is in flight from the first sample until its result pulse.
    function automatic logic state_busy(input seg_state_e s);
        return (s == SAMP) || (s == DONE) || (s == ABORT);
    endfunction

endpackage

// File: rtl/seg_link_rx_if.sv
// Serial link lines plus the decoded display outputs of the receiver.
interface seg_link_rx_if #(
    parameter int unsigned FRAME_BITS = seg_link_pkg::SEG_FRAME_BITS
) ();

    logic                                seg_data_left;
    logic                                seg_data_right;
    logic                                seg_data_cs;
    logic [FRAME_BITS-1:0]               seg_left;
    logic [FRAME_BITS-1:0]               seg_right;
    logic                                frame_valid;
    logic                                frame_err;
    logic                                busy;
    logic [seg_link_pkg::SEG_CNT_W-1:0]  frame_cnt;

    // Link driver side: drives the serial lines, observes the display outputs.
    modport master (
        output seg_data_left, seg_data_right, seg_data_cs,
        input  seg_left, seg_right, frame_valid, frame_err, busy, frame_cnt
    );

    // Receiver side.
    modport slave (
        input  seg_data_left, seg_data_right, seg_data_cs,
        output seg_left, seg_right, frame_valid, frame_err, busy, frame_cnt
    );

endinterface

// File: rtl/seg_sync2.sv
// Two-flop synchroniser for one asynchronous input line.
module seg_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Double-register the line; meta_q may go metastable, sync_q is safe to use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/seg_link_rx.sv
// Segment link receiver: frames on cs, shifts two MSB-first patterns, presents them
// to the seven-segment drivers with a valid/error strobe per frame.
module seg_link_rx
    import seg_link_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = SEG_BIT_CYCLES,
    parameter int unsigned FRAME_BITS = SEG_FRAME_BITS
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_link_rx_if.slave  link
);

    localparam int unsigned DIV_W = $clog2(BIT_CYCLES);
    localparam int unsigned BIT_W = $clog2(FRAME_BITS + 1);

    localparam logic [DIV_W-1:0] SAMPLE_AT = DIV_W'(BIT_CYCLES / 2);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);

    logic l_s;
    logic r_s;
    logic cs_s;
    logic cs_q;
    logic start_c;

    seg_state_e            state_q,  state_d;
    logic [DIV_W-1:0]      div_q,    div_d;
    logic [BIT_W-1:0]      bit_q,    bit_d;
    logic [FRAME_BITS-1:0] sh_l_q,   sh_l_d;
    logic [FRAME_BITS-1:0] sh_r_q,   sh_r_d;
    logic [FRAME_BITS-1:0] seg_l_q,  seg_l_d;
    logic [FRAME_BITS-1:0] seg_r_q,  seg_r_d;
    logic                  valid_q,  valid_d;
    logic                  err_q,    err_d;
    logic                  busy_q,   busy_d;
    logic [SEG_CNT_W-1:0]  cnt_q,    cnt_d;

    logic [FRAME_BITS-1:0] sh_l_shift;
    logic [FRAME_BITS-1:0] sh_r_shift;
    logic                  sample_c;

    seg_sync2 u_sync_l  (.clk(clk), .rst_n(rst_n), .d_i(link.seg_data_left),  .q_o(l_s));
    seg_sync2 u_sync_r  (.clk(clk), .rst_n(rst_n), .d_i(link.seg_data_right), .q_o(r_s));
    seg_sync2 u_sync_cs (.clk(clk), .rst_n(rst_n), .d_i(link.seg_data_cs),    .q_o(cs_s));

    assign start_c    = cs_s & ~cs_q;
    assign sample_c   = (div_q == SAMPLE_AT);
    assign sh_l_shift = (sh_l_q << 1) | FRAME_BITS'(l_s);
    assign sh_r_shift = (sh_r_q << 1) | FRAME_BITS'(r_s);

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q    <= 1'b0;
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_l_q  <= '0;
            sh_r_q  <= '0;
            seg_l_q <= '0;
            seg_r_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cs_q    <= cs_s;
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_l_q  <= sh_l_d;
            sh_r_q  <= sh_r_d;
            seg_l_q <= seg_l_d;
            seg_r_q <= seg_r_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. Result outputs load on the transition into DONE/ABORT so
    // that each strobe is high exactly during the one cycle spent in that state.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_l_d  = sh_l_q;
        sh_r_d  = sh_r_q;
        seg_l_d = seg_l_q;
        seg_r_d = seg_r_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                div_d = '0;
                bit_d = '0;
                if (start_c) begin
                    state_d = SAMP;
                end
            end
            SAMP: begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
                if (sample_c) begin
                    sh_l_d = sh_l_shift;
                    sh_r_d = sh_r_shift;
                    bit_d  = bit_q + BIT_W'(1);
                end
                // Losing cs wins over completing the frame, even on the last sample.
                if (!cs_s) begin
                    state_d = ABORT;
                    err_d   = 1'b1;
                end else if (sample_c && (bit_q == BIT_LAST)) begin
                    state_d = DONE;
                    seg_l_d = sh_l_shift;
                    seg_r_d = sh_r_shift;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + SEG_CNT_W'(1);
                end
            end
            DONE:    state_d = WAIT_CS;
            ABORT:   state_d = WAIT_CS;
            WAIT_CS: begin
                if (!cs_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = state_busy(state_d);
    end

    assign link.seg_left    = seg_l_q;
    assign link.seg_right   = seg_r_q;
    assign link.frame_valid = valid_q;
    assign link.frame_err   = err_q;
    assign link.busy        = busy_q;
    assign link.frame_cnt   = cnt_q;

endmodule
